sort_mem_sched: RTL and testbench
=================================

SORT_MEM_SCHED -- requirements
Module: sort_mem_sched

Interface
REQ-001 Parameters SHALL be: AW, default 6, address width; DW, default 8, data width; QD, default 4, job-queue depth (power of 2); TMO_CYC, default 4096, watchdog limit in cycles.
REQ-002 clk  in  1  the single clock; all state is updated on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous and active-low.
REQ-004 job_req  in  1  / job_left, job_right  in  AW  host job submission (sort range [left,right]).
REQ-005 job_ack  out  1  combinational; equals job_req & ~q_full.
REQ-006 job_done  out  1  one-cycle pulse per completed or dropped job; job_busy  out  1  queue non-empty or FSM not IDLE.
REQ-007 h_mem_req, h_mem_wr_en  in  1; h_mem_addr  in  AW; h_mem_wr_data  in  DW; h_mem_gnt  out  1; h_mem_rd_data  out  DW  host RAM port.
REQ-008 sort_start  out  1; sort_left, sort_right  out  AW (registered); sort_done  in  1  sorter control.
REQ-009 s_mem_wr_en  in  1; s_mem_addr  in  AW; s_mem_wr_data  in  DW; s_mem_rd_data  out  DW  sorter RAM port.
REQ-010 ram_wr_en  out  1; ram_addr  out  AW; ram_wr_data  out  DW; ram_rd_data  in  DW  shared single-port RAM.
REQ-011 jobs_cnt  out  8  count of job_done pulses, wraps 255->0; err_tmo  out  1  sticky (REQ-027).

Function
REQ-012 The job queue SHALL be a QD-entry FIFO of {left,right}; a push occurs on job_ack and a pop on the IDLE->CHECK transition.
REQ-013 A push and a pop in the same cycle SHALL leave the occupancy unchanged; when full, job_ack SHALL be 0 and the job SHALL not be stored.
REQ-014 FSM states SHALL be IDLE, CHECK, START, RUN, DONE.
REQ-015 IDLE: if the queue is non-empty, pop into sort_left/sort_right and go to CHECK; otherwise stay.
REQ-016 CHECK: if sort_left >= sort_right, go to DONE without asserting sort_start; otherwise go to START.
REQ-017 START: sort_start SHALL be 1 for exactly 3 consecutive cycles, then the FSM goes to RUN.
REQ-018 RUN: sort_start = 0; on sort_done = 1, go to DONE.
REQ-019 DONE: job_done = 1 and jobs_cnt increments for this one cycle; next state IDLE.
REQ-020 sort_done SHALL be ignored in every state except RUN.
REQ-021 Mux: in START and RUN, ram_* = s_mem_*; in all other states, ram_wr_en = h_mem_req & h_mem_wr_en & h_mem_gnt, ram_addr = h_mem_addr, and ram_wr_data = h_mem_wr_data.
REQ-022 h_mem_gnt SHALL be combinational: 1 iff state is IDLE and the queue is empty, so a pending job has priority over host access.
REQ-023 h_mem_rd_data and s_mem_rd_data SHALL both equal ram_rd_data combinationally.
REQ-024 A host write without grant SHALL be dropped; the host holds h_mem_req until h_mem_gnt = 1.

Reset
REQ-025 On rst_n = 0: FSM goes to IDLE; the queue is emptied; sort_start, job_done, and err_tmo are 0; jobs_cnt = 0; sort_left/sort_right = 0.
REQ-026 A reset during START or RUN SHALL abandon the job without a job_done pulse; the RAM mux returns to the host path immediately.

Configuration
REQ-027 With SORT_TIMEOUT_EN defined: a cycle counter clears on entry to RUN and increments each RUN cycle. If it reaches TMO_CYC without sort_done, err_tmo is set and stays set until reset, and the FSM goes to DONE (job_done is still pulsed).
REQ-028 Without SORT_TIMEOUT_EN: no counter logic exists, err_tmo is tied to 0, and RUN waits indefinitely.

Verification
REQ-029 Submit (0,7) from IDLE -> job_ack=1; CHECK, START; sort_start high 3 cycles; sort_done after 50 cycles -> job_done 1 cycle later, jobs_cnt=1.
REQ-030 Submit (5,5) and (9,2) -> 2 job_done pulses; sort_start never asserted; h_mem_gnt returns 1.
REQ-031 Submit 5 jobs back-to-back while FSM is RUN with QD=4 -> 4 acks, 5th job_ack=0; all 4 queued jobs complete in order.
REQ-032 Host write addr 3 = 0xA5 during RUN -> h_mem_gnt=0, no RAM write; after DONE->IDLE with empty queue, write succeeds and readback is 0xA5.
REQ-033 rst_n low for 1 cycle in RUN -> sort_start=0, job_done never pulsed, jobs_cnt=0, queue empty, h_mem_gnt=1.
REQ-034 With SORT_TIMEOUT_EN and TMO_CYC=16, sort_done withheld -> err_tmo=1 and job_done pulse 16 cycles after RUN entry; without the macro, FSM stays in RUN.

Source files
------------

// File: rtl/sort_mem_sched_if.sv
// Signal bundle for sort_mem_sched: host job queue, host RAM port, sorter control/RAM port, shared RAM.
interface sort_mem_sched_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          job_req;
  logic [AW-1:0] job_left;
  logic [AW-1:0] job_right;
  logic          job_ack;
  logic          job_done;
  logic          job_busy;
  logic          h_mem_req;
  logic          h_mem_wr_en;
  logic [AW-1:0] h_mem_addr;
  logic [DW-1:0] h_mem_wr_data;
  logic          h_mem_gnt;
  logic [DW-1:0] h_mem_rd_data;
  logic          sort_start;
  logic [AW-1:0] sort_left;
  logic [AW-1:0] sort_right;
  logic          sort_done;
  logic          s_mem_wr_en;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wr_data;
  logic [DW-1:0] s_mem_rd_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  logic [7:0]    jobs_cnt;
  logic          err_tmo;

  modport slave (
    input  job_req, job_left, job_right, h_mem_req, h_mem_wr_en, h_mem_addr, h_mem_wr_data,
           sort_done, s_mem_wr_en, s_mem_addr, s_mem_wr_data, ram_rd_data,
    output job_ack, job_done, job_busy, h_mem_gnt, h_mem_rd_data, sort_start, sort_left,
           sort_right, s_mem_rd_data, ram_wr_en, ram_addr, ram_wr_data, jobs_cnt, err_tmo
  );

  modport master (
    output job_req, job_left, job_right, h_mem_req, h_mem_wr_en, h_mem_addr, h_mem_wr_data,
           sort_done, s_mem_wr_en, s_mem_addr, s_mem_wr_data, ram_rd_data,
    input  job_ack, job_done, job_busy, h_mem_gnt, h_mem_rd_data, sort_start, sort_left,
           sort_right, s_mem_rd_data, ram_wr_en, ram_addr, ram_wr_data, jobs_cnt, err_tmo
  );
endinterface

// File: rtl/sort_mem_sched.sv
// Sort-job scheduler: queues {left,right} jobs, sequences an external sorter and arbitrates a shared RAM.
// Optional RUN watchdog enabled by defining SORT_TIMEOUT_EN.
module sort_mem_sched #(
  parameter int AW      = 6,
  parameter int DW      = 8,
  parameter int QD      = 4,
  parameter int TMO_CYC = 4096
) (
  input logic             clk,
  input logic             rst_n,
  sort_mem_sched_if.slave bus
);
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, START, RUN, DONE} state_t;

  state_t        state;
  logic [1:0]    start_cnt;
  logic          sort_start;
  logic          job_done;
  logic [7:0]    jobs_cnt;
  logic [AW-1:0] sort_left;
  logic [AW-1:0] sort_right;
  logic          tmo_hit;

  logic [AW-1:0] q_left  [QD];
  logic [AW-1:0] q_right [QD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   q_cnt;
  logic          q_empty;
  logic          q_full;
  logic          push;
  logic          pop;
  logic          gnt;
  logic          s_path;

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == (PW+1)'(QD));
  assign push    = bus.job_req & ~q_full;
  assign pop     = (state == IDLE) & ~q_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      q_left[wr_ptr]  <= bus.job_left;
      q_right[wr_ptr] <= bus.job_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // sort_done only matters in RUN; the watchdog can also end RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_cnt  <= '0;
      sort_start <= 1'b0;
      job_done   <= 1'b0;
      jobs_cnt   <= '0;
      sort_left  <= '0;
      sort_right <= '0;
    end else begin
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            sort_left  <= q_left[rd_ptr];
            sort_right <= q_right[rd_ptr];
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (sort_left >= sort_right) begin
            state    <= DONE;
            job_done <= 1'b1;
            jobs_cnt <= jobs_cnt + 1'b1;
          end else begin
            state      <= START;
            sort_start <= 1'b1;
            start_cnt  <= '0;
          end
        end
        START: begin
          if (start_cnt == 2'd2) begin
            state      <= RUN;
            sort_start <= 1'b0;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.sort_done || tmo_hit) begin
            state    <= DONE;
            job_done <= 1'b1;
            jobs_cnt <= jobs_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SORT_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_tmo;

  // counter holds k in the k-th RUN cycle, so the last allowed cycle is TMO_CYC-1
  assign tmo_hit = (state == RUN) && (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      if (state == START)    tmo_cnt <= '0;
      else if (state == RUN) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit && !bus.sort_done) err_tmo <= 1'b1;
    end
  end

  assign bus.err_tmo = err_tmo;
`else
  assign tmo_hit     = 1'b0;
  assign bus.err_tmo = 1'b0;
`endif

  assign gnt    = (state == IDLE) & q_empty;
  assign s_path = (state == START) | (state == RUN);

  assign bus.job_ack       = push;
  assign bus.job_done      = job_done;
  assign bus.job_busy      = ~q_empty | (state != IDLE);
  assign bus.jobs_cnt      = jobs_cnt;
  assign bus.sort_start    = sort_start;
  assign bus.sort_left     = sort_left;
  assign bus.sort_right    = sort_right;
  assign bus.h_mem_gnt     = gnt;
  assign bus.ram_wr_en     = s_path ? bus.s_mem_wr_en   : (bus.h_mem_req & bus.h_mem_wr_en & gnt);
  assign bus.ram_addr      = s_path ? bus.s_mem_addr    : bus.h_mem_addr;
  assign bus.ram_wr_data   = s_path ? bus.s_mem_wr_data : bus.h_mem_wr_data;
  assign bus.h_mem_rd_data = bus.ram_rd_data;
  assign bus.s_mem_rd_data = bus.ram_rd_data;
endmodule

// File: tb/tb_sort_mem_sched.sv
// Directed bench for sort_mem_sched with a behavioural shared RAM and a hand-driven sorter.
module tb_sort_mem_sched;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int QD = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_mem_sched_if #(.AW(AW), .DW(DW)) bus ();

  sort_mem_sched #(.AW(AW), .DW(DW), .QD(QD), .TMO_CYC(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] ram [64];
  always @(posedge clk) if (bus.ram_wr_en) ram[bus.ram_addr] <= bus.ram_wr_data;
  assign bus.ram_rd_data = ram[bus.ram_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic submit(input logic [AW-1:0] l, input logic [AW-1:0] r, output logic ack);
    bus.job_left  = l;
    bus.job_right = r;
    bus.job_req   = 1'b1;
    #1 ack = bus.job_ack;
    @(negedge clk);
    bus.job_req = 1'b0;
  endtask

  task automatic wait_start(input logic lvl, input string tag);
    int k = 0;
    while (bus.sort_start !== lvl && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) chk({tag, "_wait"}, bus.sort_start, lvl);
  endtask

  task automatic finish_job(input string tag);
    bus.sort_done = 1'b1;
    @(negedge clk);
    bus.sort_done = 1'b0;
    chk({tag, "_done"}, bus.job_done, 1);
  endtask

  task automatic run_job(input logic [AW-1:0] l, input logic [AW-1:0] r, input string tag);
    wait_start(1'b1, tag);
    chk({tag, "_left"}, bus.sort_left, l);
    chk({tag, "_right"}, bus.sort_right, r);
    wait_start(1'b0, tag);
    repeat (3) @(negedge clk);
    finish_job(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ack, a1, a2;
    logic [4:0] acks;
    int hi, dn, st, k;

    bus.job_req = 0;  bus.job_left = 0;  bus.job_right = 0;
    bus.h_mem_req = 0; bus.h_mem_wr_en = 0; bus.h_mem_addr = 0; bus.h_mem_wr_data = 0;
    bus.sort_done = 0; bus.s_mem_wr_en = 0; bus.s_mem_addr = 0; bus.s_mem_wr_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_sort_start", bus.sort_start, 0);
    chk("rst_job_done", bus.job_done, 0);
    chk("rst_jobs_cnt", bus.jobs_cnt, 0);
    chk("rst_err_tmo", bus.err_tmo, 0);
    chk("rst_gnt", bus.h_mem_gnt, 1);
    chk("rst_busy", bus.job_busy, 0);
    chk("rst_left", bus.sort_left, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job (0,7): CHECK, 3-cycle start, sort_done after ~50 cycles
    submit(0, 7, ack);
    chk("j1_ack", ack, 1);
    chk("j1_gnt_pending", bus.h_mem_gnt, 0);
    chk("j1_busy", bus.job_busy, 1);
    @(negedge clk);
    chk("j1_check_start", bus.sort_start, 0);
    chk("j1_check_left", bus.sort_left, 0);
    chk("j1_check_right", bus.sort_right, 7);
    hi = 0;
    repeat (11) begin
      @(negedge clk);
      if (bus.sort_start) hi++;
    end
    chk("j1_start_cycles", hi, 3);
    repeat (37) @(negedge clk);
    finish_job("j1");
    chk("j1_cnt", bus.jobs_cnt, 1);
    @(negedge clk);
    chk("j1_pulse_len", bus.job_done, 0);
    chk("j1_gnt_back", bus.h_mem_gnt, 1);

    // Degenerate ranges skip the sorter
    submit(5, 5, a1);
    submit(9, 2, a2);
    chk("deg_ack1", a1, 1);
    chk("deg_ack2", a2, 1);
    dn = 0; st = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.job_done) dn++;
      if (bus.sort_start) st++;
    end
    chk("deg_done_pulses", dn, 2);
    chk("deg_no_start", st, 0);
    chk("deg_gnt", bus.h_mem_gnt, 1);
    chk("deg_cnt", bus.jobs_cnt, 3);

    // Queue overflow while the sorter is busy, then in-order drain
    submit(0, 7, ack);
    wait_start(1'b1, "ov_run");
    wait_start(1'b0, "ov_run");
    for (int i = 0; i < 5; i++) begin
      submit(AW'(i + 1), AW'(i + 10), ack);
      acks[i] = ack;
    end
    chk("ov_acks", acks, 5'b01111);
    chk("ov_busy", bus.job_busy, 1);
    finish_job("ov_q0");
    for (int i = 0; i < 4; i++) run_job(AW'(i + 1), AW'(i + 10), $sformatf("ov_q%0d", i + 1));
    chk("ov_cnt", bus.jobs_cnt, 8);

    // Host write blocked during RUN, sorter owns the RAM
    submit(0, 7, ack);
    wait_start(1'b1, "hw_run");
    wait_start(1'b0, "hw_run");
    bus.h_mem_req = 1; bus.h_mem_wr_en = 1; bus.h_mem_addr = 3; bus.h_mem_wr_data = 8'hA5;
    bus.s_mem_wr_en = 1; bus.s_mem_addr = 9; bus.s_mem_wr_data = 8'h3C;
    #1;
    chk("hw_gnt_run", bus.h_mem_gnt, 0);
    chk("hw_sorter_wr", bus.ram_wr_en, 1);
    chk("hw_sorter_addr", bus.ram_addr, 9);
    @(negedge clk);
    bus.s_mem_wr_en = 0;
    #1;
    chk("hw_host_blocked", bus.ram_wr_en, 0);
    chk("hw_sorter_rd", bus.s_mem_rd_data, 8'h3C);
    repeat (2) @(negedge clk);
    finish_job("hw");
    chk("hw_gnt_done", bus.h_mem_gnt, 0);
    @(negedge clk);
    chk("hw_gnt_idle", bus.h_mem_gnt, 1);
    chk("hw_wr_en_idle", bus.ram_wr_en, 1);
    @(negedge clk);
    bus.h_mem_req = 0; bus.h_mem_wr_en = 0;
    #1;
    chk("hw_readback", bus.h_mem_rd_data, 8'hA5);
    chk("hw_cnt", bus.jobs_cnt, 9);

    // Sorter never finishes
    submit(0, 7, ack);
    wait_start(1'b1, "tmo_run");
    wait_start(1'b0, "tmo_run");
`ifdef SORT_TIMEOUT_EN
    k = 0;
    while (!bus.job_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", k, TMO);
    chk("tmo_err", bus.err_tmo, 1);
    @(negedge clk);
    chk("tmo_err_sticky", bus.err_tmo, 1);
`else
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.job_done) dn++;
    end
    chk("tmo_no_done", dn, 0);
    chk("tmo_still_busy", bus.job_busy, 1);
    chk("tmo_err_off", bus.err_tmo, 0);
    finish_job("tmo_release");
    @(negedge clk);
`endif
    chk("tmo_cnt", bus.jobs_cnt, 10);

    // Asynchronous reset in RUN abandons the job and the queue
    submit(0, 7, ack);
    wait_start(1'b1, "rr_run");
    wait_start(1'b0, "rr_run");
    submit(1, 2, ack);
    chk("rr_queued_ack", ack, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_start", bus.sort_start, 0);
    chk("rr_gnt", bus.h_mem_gnt, 1);
    chk("rr_busy", bus.job_busy, 0);
    chk("rr_cnt", bus.jobs_cnt, 0);
    chk("rr_err", bus.err_tmo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.job_done) dn++;
    end
    chk("rr_no_done", dn, 0);
    chk("rr_gnt_after", bus.h_mem_gnt, 1);
    chk("rr_cnt_after", bus.jobs_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
